// File: rtl/sdm_sample_sched.sv
// Sample scheduler for the first-order sigma-delta modulator: buffers upstream samples in a FIFO
// and presents one to the modulator every DIV clocks, with priming, underrun and drain/tail phases.
module sdm_sample_sched #(
   parameter int unsigned  N         = 16,
   parameter int unsigned  DIV       = 2,
   parameter int unsigned  DEPTH     = 8,
   parameter int unsigned  PRIME     = 4,
   parameter int unsigned  TAIL      = 10,
   parameter logic [N-1:0] IDLE_CODE = '0
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         start,
   input  logic         stop,
   input  logic [N-1:0] s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic [N-1:0] dout,
   output logic         dout_stb,
   output logic         busy,
   output logic [15:0]  underrun_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned RW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TW = (TAIL > 1) ? $clog2(TAIL) : 1;

   typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

   state_e         state_q, state_d;
   logic [RW-1:0]  rate_q, rate_d;
   logic [TW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [N-1:0]   dout_q, dout_d;
   logic [15:0]    urun_q, urun_d;
   logic [N-1:0]   mem_q [DEPTH];

   logic playing, tick, fifo_empty, pop, wr_en, tail_done;

   assign playing    = (state_q == StRun) || (state_q == StDrain);
   assign tick       = playing && (rate_q == RW'(DIV - 1));
   assign fifo_empty = (count_q == '0);
   assign pop        = tick && !fifo_empty;
   assign wr_en      = s_valid && s_ready;
   // TAIL of zero ends the drain as soon as the FIFO runs dry.
   assign tail_done  = (TAIL == 0) || (tick && (tail_q == TW'(TAIL - 1)));

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start && !stop) state_d = StFill;
         StFill: begin
            if (stop) begin
               state_d = StIdle;
            end else if (count_q >= CW'(PRIME)) begin
               state_d = StRun;
            end
         end
         StRun:   if (stop) state_d = StDrain;
         StDrain: if (fifo_empty && tail_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      s_ready  = ((state_q == StFill) || (state_q == StRun)) && (count_q < CW'(DEPTH));
      dout_stb = tick;
      busy     = (state_q != StIdle);
   end

   always_comb begin
      rate_d = '0;
      if (playing && !tick) rate_d = rate_q + RW'(1);

      tail_d = '0;
      if (state_q == StDrain) tail_d = (tick && fifo_empty) ? tail_q + TW'(1) : tail_q;

      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(wr_en) - CW'(pop);
      // Entering or sitting in IDLE flushes the FIFO, including a word accepted alongside stop.
      if (state_d == StIdle) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      dout_d = dout_q;
      if (state_q == StIdle) begin
         dout_d = IDLE_CODE;
      end else if (tick) begin
         dout_d = pop ? mem_q[rd_ptr_q] : IDLE_CODE;
      end

      urun_d = urun_q;
      if ((state_q == StIdle) && start && !stop) begin
         urun_d = '0;
      end else if (tick && (state_q == StRun) && fifo_empty && (urun_q != 16'hFFFF)) begin
         urun_d = urun_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         rate_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= IDLE_CODE;
         urun_q   <= '0;
      end else begin
         rate_q   <= rate_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         urun_q   <= urun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= s_data;
   end

   assign dout         = dout_q;
   assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_sdm_sample_sched.sv
// Bench for sdm_sample_sched: directed scenarios plus random traffic, all checked against a
// queue-based model of the scheduler's play-out rules.
module tb_sdm_sample_sched;

   localparam int N = 16, DIV = 2, DEPTH = 8, PRIME = 4, TAIL = 10;

   logic          clk = 1'b0;
   logic          areset, start, stop, s_valid, s_ready, dout_stb, busy;
   logic [N-1:0]  s_data, dout;
   logic [15:0]   underrun_cnt;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sdm_sample_sched #(
      .N(N), .DIV(DIV), .DEPTH(DEPTH), .PRIME(PRIME), .TAIL(TAIL), .IDLE_CODE('0)
   ) dut (
      .clk(clk), .areset(areset), .start(start), .stop(stop), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .dout(dout), .dout_stb(dout_stb), .busy(busy),
      .underrun_cnt(underrun_cnt)
   );

   // Model: 0 idle, 1 fill, 2 run, 3 drain; phase counts clocks since playback began, mod DIV.
   int          m_state, m_phase, m_tail;
   logic [15:0] mq[$];
   logic [15:0] m_dout, m_urun;

   function automatic bit m_ready();
      return (m_state == 1 || m_state == 2) && (mq.size() < DEPTH);
   endfunction

   function automatic bit m_stb();
      return (m_state == 2 || m_state == 3) && (m_phase == DIV - 1);
   endfunction

   task automatic model_reset();
      m_state = 0; m_phase = 0; m_tail = 0; m_dout = '0; m_urun = '0;
      mq.delete();
   endtask

   task automatic model_advance();
      bit acc = s_valid && m_ready();
      bit stb = m_stb();
      int sz  = mq.size();
      int old = m_state;
      case (m_state)
         0: if (start && !stop) begin m_state = 1; m_urun = '0; end
         1: begin
            if (acc) mq.push_back(s_data);
            if (stop) begin m_state = 0; mq.delete(); end
            else if (sz >= PRIME) m_state = 2;
         end
         2: begin
            if (stb) begin
               if (sz > 0) m_dout = mq.pop_front();
               else begin m_dout = '0; if (m_urun != 16'hFFFF) m_urun++; end
            end
            if (acc) mq.push_back(s_data);
            if (stop) m_state = 3;
         end
         default: if (stb) begin
            if (sz > 0) m_dout = mq.pop_front();
            else begin
               m_dout = '0; m_tail++;
               if (m_tail == TAIL) begin m_state = 0; m_tail = 0; end
            end
         end
      endcase
      m_phase = (old == 2 || old == 3) ? (m_phase + 1) % DIV : 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic test_reset();
      start = 0; stop = 0; s_valid = 0; s_data = '0; areset = 1;
      @(negedge clk);
      areset = 0;
      #1;
      model_reset();
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", s_ready); else n_pass++;
      n_total++; if (dout !== 16'h0) $display("FAIL rst_dout got=%h exp=0000", dout); else n_pass++;
      n_total++; if (dout_stb !== 1'b0) $display("FAIL rst_stb got=%b exp=0", dout_stb); else n_pass++;
      n_total++; if (underrun_cnt !== 16'h0) $display("FAIL rst_urun got=%h exp=0", underrun_cnt);
      else n_pass++;
      @(negedge clk);
      areset = 1;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         n_total++; if (busy !== 1'b1) $display("FAIL fill_busy got=%b exp=1", busy); else n_pass++;
         n_total++; if (dout_stb !== 1'b0) $display("FAIL fill_stb got=%b exp=0", dout_stb);
         else n_pass++;
         n_total++; if (dout !== 16'h0) $display("FAIL fill_dout got=%h exp=0000", dout); else n_pass++;
      end
   endtask

   task automatic test_prime_play();
      logic [15:0] vals[4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
      logic [15:0] got[$];
      int          stb_cyc[$];
      bit          was;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1; s_data = vals[i]; cycle();
      end
      s_valid = 0;
      for (int c = 0; c < 60 && got.size() < 7; c++) begin
         n_total++; if (dout_stb !== m_stb()) $display("FAIL play_stb got=%b exp=%b", dout_stb, m_stb());
         else n_pass++;
         was = dout_stb;
         cycle();
         if (was) begin got.push_back(dout); stb_cyc.push_back(c); end
         n_total++; if (dout !== m_dout) $display("FAIL play_dout got=%h exp=%h", dout, m_dout);
         else n_pass++;
      end
      n_total++; if (got.size() != 7) $display("FAIL play_count got=%0d exp=7", got.size());
      else n_pass++;
      for (int i = 0; i < got.size(); i++) begin
         n_total++;
         if (got[i] !== ((i < 4) ? vals[i] : 16'h0))
            $display("FAIL play_val%0d got=%h exp=%h", i, got[i], (i < 4) ? vals[i] : 16'h0);
         else n_pass++;
      end
      for (int i = 1; i < stb_cyc.size(); i++) begin
         n_total++; if (stb_cyc[i] - stb_cyc[i-1] != DIV)
            $display("FAIL play_spacing got=%0d exp=%0d", stb_cyc[i] - stb_cyc[i-1], DIV);
         else n_pass++;
      end
      n_total++; if (underrun_cnt !== 16'd3) $display("FAIL urun3 got=%0d exp=3", underrun_cnt);
      else n_pass++;
      s_valid = 1; s_data = 16'hABCD; cycle(); s_valid = 0;
      cycle();
      n_total++; if (dout !== 16'hABCD) $display("FAIL urun_recover got=%h exp=abcd", dout);
      else n_pass++;
      n_total++; if (underrun_cnt !== 16'd3) $display("FAIL urun_hold got=%0d exp=3", underrun_cnt);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit saw_full = 0;
      s_valid = 1; s_data = 16'($urandom);
      for (int c = 0; c < 40; c++) begin
         bit acc;
         n_total++; if (s_ready !== m_ready()) $display("FAIL bp_ready got=%b exp=%b", s_ready, m_ready());
         else n_pass++;
         if (!s_ready) saw_full = 1;
         acc = m_ready();
         cycle();
         n_total++; if (dout !== m_dout) $display("FAIL bp_dout got=%h exp=%h", dout, m_dout);
         else n_pass++;
         if (acc) s_data = 16'($urandom);
      end
      s_valid = 0;
      n_total++; if (saw_full !== 1'b1) $display("FAIL bp_full got=%b exp=1", saw_full); else n_pass++;
   endtask

   task automatic test_stop_drain();
      logic [15:0] exp_q[$];
      logic [15:0] got[$];
      bit          was;
      int          nz = 0;
      s_valid = 0;
      for (int c = 0; c < 100 && (mq.size() > 3 || m_stb()); c++) begin
         cycle();
         n_total++; if (dout !== m_dout) $display("FAIL dr_pre got=%h exp=%h", dout, m_dout);
         else n_pass++;
      end
      exp_q = mq;
      stop = 1; cycle(); stop = 0;
      for (int c = 0; c < 100 && busy; c++) begin
         n_total++; if (s_ready !== 1'b0) $display("FAIL dr_ready got=%b exp=0", s_ready); else n_pass++;
         n_total++; if (dout_stb !== m_stb()) $display("FAIL dr_stb got=%b exp=%b", dout_stb, m_stb());
         else n_pass++;
         was = dout_stb;
         cycle();
         if (was) got.push_back(dout);
      end
      n_total++; if (got.size() != exp_q.size() + TAIL)
         $display("FAIL dr_count got=%0d exp=%0d", got.size(), exp_q.size() + TAIL);
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_total++; if (got[i] !== exp_q[i]) $display("FAIL dr_val%0d got=%h exp=%h", i, got[i], exp_q[i]);
         else n_pass++;
      end
      for (int i = exp_q.size(); i < got.size(); i++) if (got[i] !== 16'h0) nz++;
      n_total++; if (nz != 0) $display("FAIL dr_tail nonidle=%0d exp=0", nz); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL dr_busy got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_edges();
      logic [15:0] v[PRIME];
      bit          was, seen = 0;
      start = 1; stop = 1; cycle(); start = 0; stop = 0; cycle();
      n_total++; if (busy !== 1'b0) $display("FAIL ss_busy got=%b exp=0", busy); else n_pass++;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 2; i++) begin s_valid = 1; s_data = 16'($urandom); cycle(); end
      s_valid = 0; stop = 1; cycle(); stop = 0;
      n_total++; if (busy !== 1'b0) $display("FAIL fstop_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL fstop_ready got=%b exp=0", s_ready); else n_pass++;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < PRIME; i++) begin
         v[i] = 16'($urandom) | 16'h0001;
         s_valid = 1; s_data = v[i]; cycle();
      end
      s_valid = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         was = dout_stb; cycle();
         if (was) seen = 1;
      end
      n_total++; if (dout !== v[0]) $display("FAIL flush_first got=%h exp=%h", dout, v[0]); else n_pass++;
      @(posedge clk); #2;
      areset = 0;
      #1;
      model_reset();
      n_total++; if (busy !== 1'b0) $display("FAIL mrst_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (dout !== 16'h0) $display("FAIL mrst_dout got=%h exp=0000", dout); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL mrst_ready got=%b exp=0", s_ready); else n_pass++;
      n_total++; if (dout_stb !== 1'b0) $display("FAIL mrst_stb got=%b exp=0", dout_stb); else n_pass++;
      @(negedge clk);
      areset = 1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         n_total++; if (dout !== m_dout) $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, dout, m_dout);
         else n_pass++;
         n_total++; if (dout_stb !== m_stb())
            $display("FAIL rnd_stb c=%0d got=%b exp=%b", c, dout_stb, m_stb());
         else n_pass++;
         n_total++; if (s_ready !== m_ready())
            $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, s_ready, m_ready());
         else n_pass++;
         n_total++; if (busy !== (m_state != 0))
            $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_state != 0);
         else n_pass++;
         n_total++; if (underrun_cnt !== m_urun)
            $display("FAIL rnd_urun c=%0d got=%0d exp=%0d", c, underrun_cnt, m_urun);
         else n_pass++;
         start   = ($urandom_range(19) == 0);
         stop    = ($urandom_range(59) == 0);
         s_valid = ($urandom_range(2) != 0);
         s_data  = 16'($urandom);
         cycle();
      end
      start = 0; stop = 0; s_valid = 0;
   endtask

   initial begin
      test_reset();
      test_prime_play();
      test_backpressure();
      test_stop_drain();
      test_edges();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
